ss_tile_collision_probe: RTL and testbench

Collision front-end for the player physics logic. It reads the active world map's logic port (worldmap_addr / worldmap_data, 2-bit tile codes) and returns the four tiles around the player's tile position.
- Sits directly upstream of the map muxer, on the logic-side address/data pair.
- Hides BRAM read latency, map edges and map switches from the physics FSM.

---
 rtl/ss_tile_pkg.sv | 42 ++++
 rtl/ss_probe_tag_pipe.sv | 39 +++
 rtl/ss_tile_collision_probe.sv | 234 +++++++++++++++++++++++
 tb/tb_ss_tile_collision_probe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_tile_pkg.sv
// Shared types for the tile collision probe: tile codes, probe slot
// indices, FSM states and the tag that travels alongside each BRAM read.
package ss_tile_pkg;

  localparam int MAP_ADDR_W = 14;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    SOLID  = 2'd1,
    HAZARD = 2'd2,
    GOAL   = 2'd3
  } tile_t;

  typedef logic [1:0] probe_idx_t;

  // Issue order of the four neighbour probes.
  localparam probe_idx_t PROBE_BELOW = 2'd0;
  localparam probe_idx_t PROBE_ABOVE = 2'd1;
  localparam probe_idx_t PROBE_LEFT  = 2'd2;
  localparam probe_idx_t PROBE_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Travels with each read so the returning data can be steered to its slot.
  typedef struct packed {
    logic       valid;
    probe_idx_t idx;
    logic       forced;
    tile_t      forced_code;
  } probe_tag_t;

  // Off-map neighbours: below the bottom row is a pit, every other edge is wall.
  function automatic tile_t edge_code(input probe_idx_t idx);
    return (idx == PROBE_BELOW) ? HAZARD : SOLID;
  endfunction

endpackage

// File: rtl/ss_probe_tag_pipe.sv
// Delay line that keeps a probe's tag aligned with its BRAM data, DEPTH
// cycles behind the address. A flush empties every stage at once.
module ss_probe_tag_pipe
  import ss_tile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_75,
  input  logic       flush,
  input  probe_tag_t push_tag,
  output probe_tag_t pop_tag
);

  probe_tag_t [DEPTH-1:0] stage_q;
  probe_tag_t [DEPTH-1:0] stage_d;

  // Shift one stage per cycle, or clear everything on flush.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else begin
      stage_d[0] = push_tag;
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  // Stage registers; the flush input doubles as the reset path.
  always_ff @(posedge clk_75) begin
    // NOTE: no separate reset here -- the parent ties its reset into flush, which clears every stage.
    stage_q <= stage_d;
  end

  assign pop_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/ss_tile_collision_probe.sv
// Reads the four tiles around the player's tile from the active world map,
// hiding BRAM latency, map edges and map switches behind a fixed-latency
// request/done handshake.
module ss_tile_collision_probe
  import ss_tile_pkg::*;
#(
  parameter int MAP_W_LOG2 = 7,
  parameter int MAP_H_LOG2 = 7,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk_75,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [MAP_W_LOG2-1:0] tile_x,
  input  logic [MAP_H_LOG2-1:0] tile_y,
  input  logic                  map_changed,
  output logic [MAP_ADDR_W-1:0] worldmap_addr,
  input  logic [1:0]            worldmap_data,
  output logic [1:0]            tile_below,
  output logic [1:0]            tile_above,
  output logic [1:0]            tile_left,
  output logic [1:0]            tile_right,
  output logic                  on_ground,
  output logic                  hazard_hit,
  output logic                  done
);

  // Registered state.
  state_t                state_q, state_d;
  probe_idx_t            issue_idx_q, issue_idx_d;
  logic [MAP_W_LOG2-1:0] lat_x_q, lat_x_d;
  logic [MAP_H_LOG2-1:0] lat_y_q, lat_y_d;
  logic [MAP_ADDR_W-1:0] addr_q, addr_d;
  logic                  slot_forced_q, slot_forced_d;
  tile_t                 slot_code_q, slot_code_d;
  tile_t [3:0]           res_q, res_d;   // per-slot staging, indexed by probe
  tile_t [3:0]           out_q, out_d;   // published result set
  logic                  on_ground_q, on_ground_d;
  logic                  hazard_q, hazard_d;
  logic                  done_q, done_d;

  // Next-probe selection.
  logic                  restart;
  logic                  sel_load;
  logic [MAP_W_LOG2-1:0] sel_x;
  logic [MAP_H_LOG2-1:0] sel_y;
  probe_idx_t            sel_idx;

  // Neighbour of the selected probe, one extra bit so edges do not wrap.
  logic [MAP_W_LOG2:0]   nb_x;
  logic [MAP_H_LOG2:0]   nb_y;
  logic                  nb_oob;
  logic [MAP_ADDR_W-1:0] nb_addr;

  // Tag pipe interface.
  probe_tag_t            push_tag;
  probe_tag_t            pop_tag;
  logic                  pipe_flush;
  logic                  capture;
  tile_t                 capture_code;

  // A map switch only matters while reads for the current request are in flight.
  assign restart    = map_changed && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
  assign pipe_flush = reset || map_changed;

  ss_probe_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk_75   (clk_75),
    .flush    (pipe_flush),
    .push_tag (push_tag),
    .pop_tag  (pop_tag)
  );

  // Choose which probe's address is loaded at the coming edge, if any.
  always_comb begin
    sel_load = 1'b0;
    sel_x    = lat_x_q;
    sel_y    = lat_y_q;
    sel_idx  = PROBE_BELOW;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          sel_load = 1'b1;
          sel_x    = tile_x;
          sel_y    = tile_y;
        end
      end
      ST_ISSUE: begin
        if (restart) begin
          sel_load = 1'b1;
        end else if (issue_idx_q != PROBE_RIGHT) begin
          sel_load = 1'b1;
          sel_idx  = issue_idx_q + 2'd1;
        end
      end
      ST_DRAIN: begin
        if (restart) begin
          sel_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Neighbour coordinate and map address of the selected probe.
  always_comb begin
    nb_x = {1'b0, sel_x};
    nb_y = {1'b0, sel_y};
    unique case (sel_idx)
      PROBE_BELOW: nb_y = nb_y + 1'b1;
      PROBE_ABOVE: nb_y = nb_y - 1'b1;
      PROBE_LEFT:  nb_x = nb_x - 1'b1;
      default:     nb_x = nb_x + 1'b1;
    endcase
    nb_oob  = nb_x[MAP_W_LOG2] || nb_y[MAP_H_LOG2];
    nb_addr = MAP_ADDR_W'({nb_y[MAP_H_LOG2-1:0], nb_x[MAP_W_LOG2-1:0]});
  end

  // FSM next state, address issue, result capture and publication.
  always_comb begin
    state_d       = state_q;
    issue_idx_d   = issue_idx_q;
    lat_x_d       = lat_x_q;
    lat_y_d       = lat_y_q;
    addr_d        = addr_q;
    slot_forced_d = slot_forced_q;
    slot_code_d   = slot_code_q;
    res_d         = res_q;
    out_d         = out_q;
    on_ground_d   = on_ground_q;
    hazard_d      = hazard_q;
    done_d        = 1'b0;
    push_tag      = '0;

    // Entering a new issue slot: off-map slots keep the old address on the bus.
    if (sel_load) begin
      issue_idx_d   = sel_idx;
      slot_forced_d = nb_oob;
      slot_code_d   = edge_code(sel_idx);
      if (!nb_oob) begin
        addr_d = nb_addr;
      end
    end

    // The slot whose address is on the bus this cycle sends its tag down the pipe.
    if (state_q == ST_ISSUE) begin
      push_tag = '{valid: 1'b1, idx: issue_idx_q, forced: slot_forced_q,
                   forced_code: slot_code_q};
    end

    // Returning data lands in its slot unless a map switch voids it.
    capture      = pop_tag.valid && !restart &&
                   ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
    capture_code = pop_tag.forced ? pop_tag.forced_code : tile_t'(worldmap_data);
    if (capture) begin
      res_d[pop_tag.idx] = capture_code;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          lat_x_d = tile_x;
          lat_y_d = tile_y;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!restart && (issue_idx_q == PROBE_RIGHT)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (restart) begin
          state_d = ST_ISSUE;
        end else if (capture && (pop_tag.idx == PROBE_RIGHT)) begin
          state_d     = ST_DONE;
          out_d       = res_d;
          on_ground_d = (res_d[PROBE_BELOW] == SOLID);
          hazard_d    = (res_d[PROBE_BELOW] == HAZARD) || (res_d[PROBE_ABOVE] == HAZARD) ||
                        (res_d[PROBE_LEFT]  == HAZARD) || (res_d[PROBE_RIGHT] == HAZARD);
          done_d      = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk_75) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (reset) begin
      state_q       <= ST_IDLE;
      issue_idx_q   <= PROBE_BELOW;
      lat_x_q       <= '0;
      lat_y_q       <= '0;
      addr_q        <= '0;
      slot_forced_q <= 1'b0;
      slot_code_q   <= EMPTY;
      res_q         <= {4{EMPTY}};
      out_q         <= {4{EMPTY}};
      on_ground_q   <= 1'b0;
      hazard_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_idx_q   <= issue_idx_d;
      lat_x_q       <= lat_x_d;
      lat_y_q       <= lat_y_d;
      addr_q        <= addr_d;
      slot_forced_q <= slot_forced_d;
      slot_code_q   <= slot_code_d;
      res_q         <= res_d;
      out_q         <= out_d;
      on_ground_q   <= on_ground_d;
      hazard_q      <= hazard_d;
      done_q        <= done_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign worldmap_addr = addr_q;
  assign tile_below    = out_q[PROBE_BELOW];
  assign tile_above    = out_q[PROBE_ABOVE];
  assign tile_left     = out_q[PROBE_LEFT];
  assign tile_right    = out_q[PROBE_RIGHT];
  assign on_ground     = on_ground_q;
  assign hazard_hit    = hazard_q;
  assign done          = done_q;

endmodule

// File: tb/tb_ss_tile_collision_probe.sv
// Self-checking bench for ss_tile_collision_probe: directed vector table,
// hand-written reset / back-to-back sequences, then randomized requests
// against a coordinate-level reference model and a two-map BRAM model.
module tb_ss_tile_collision_probe;

  localparam int RD_LAT = 2;
  localparam int MW     = 128;
  localparam int NCELL  = MW * MW;

  logic        clk_75 = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  tile_x;
  logic [6:0]  tile_y;
  logic        map_changed;
  logic [13:0] worldmap_addr;
  logic [1:0]  worldmap_data;
  logic [1:0]  tile_below, tile_above, tile_left, tile_right;
  logic        on_ground, hazard_hit, done;

  always #5 clk_75 = ~clk_75;

  ss_tile_collision_probe #(
    .MAP_W_LOG2 (7),
    .MAP_H_LOG2 (7),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk_75        (clk_75),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .tile_x        (tile_x),
    .tile_y        (tile_y),
    .map_changed   (map_changed),
    .worldmap_addr (worldmap_addr),
    .worldmap_data (worldmap_data),
    .tile_below    (tile_below),
    .tile_above    (tile_above),
    .tile_left     (tile_left),
    .tile_right    (tile_right),
    .on_ground     (on_ground),
    .hazard_hit    (hazard_hit),
    .done          (done)
  );

  // Two world maps behind a muxer; reads return RD_LAT cycles after the address.
  logic [1:0]  map_a [NCELL];
  logic [1:0]  map_b [NCELL];
  logic        map_sel;
  logic [13:0] addr_hist [RD_LAT];

  always @(posedge clk_75) begin
    addr_hist[0] <= worldmap_addr;
    for (int k = 1; k < RD_LAT; k++) addr_hist[k] <= addr_hist[k-1];
  end

  assign worldmap_data = map_sel ? map_b[addr_hist[RD_LAT-1]] : map_a[addr_hist[RD_LAT-1]];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nb_col(input int x, input int p);
    return (p == 2) ? x - 1 : (p == 3) ? x + 1 : x;
  endfunction

  function automatic int nb_row(input int y, input int p);
    return (p == 0) ? y + 1 : (p == 1) ? y - 1 : y;
  endfunction

  function automatic bit in_map(input int c, input int r);
    return (c >= 0) && (c < MW) && (r >= 0) && (r < MW);
  endfunction

  function automatic int ref_tile(input int x, input int y, input int p, input bit s);
    int c, r;
    c = nb_col(x, p);
    r = nb_row(y, p);
    if (!in_map(c, r)) return (p == 0) ? 2 : 1;
    return s ? int'(map_b[r*MW + c]) : int'(map_a[r*MW + c]);
  endfunction

  // Probe index whose address appears in cycle c, or -1 for none.
  function automatic int issue_probe(input int c, input int mc);
    bit rs;
    rs = (mc >= 1) && (mc <= 6);
    if (rs && c > mc) return (c - mc - 1 < 4) ? c - mc - 1 : -1;
    if (c >= 1 && c <= 4 && (!rs || c <= mc)) return c - 1;
    return -1;
  endfunction

  function automatic int final_addr(input int x, input int y, input int prev);
    int cur;
    cur = prev;
    for (int p = 0; p < 4; p++)
      if (in_map(nb_col(x, p), nb_row(y, p))) cur = nb_row(y, p) * MW + nb_col(x, p);
    return cur;
  endfunction

  int prev_addr;

  // ---------------- one request, sampled cycle by cycle ----------------
  task automatic do_request(input string nm, input int x, input int y, input int mc,
                            input int e0, input int e1, input int e2, input int e3,
                            input int exp_done);
    int addr_seen [21];
    int done_cnt, done_c, cur, p;
    int r0, r1, r2, r3, og, hz;
    done_cnt = 0; done_c = -1;
    r0 = -1; r1 = -1; r2 = -1; r3 = -1; og = -1; hz = -1;
    @(negedge clk_75);
    check({nm, "_ready_c0"}, int'(req_ready), 1);
    req_valid = 1'b1; tile_x = 7'(x); tile_y = 7'(y);
    if (mc == 0) begin map_changed = 1'b1; map_sel = ~map_sel; end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_75);
      req_valid = 1'b0; map_changed = 1'b0;
      addr_seen[c] = int'(worldmap_addr);
      if (done) begin
        done_cnt++;
        if (done_c < 0) begin
          done_c = c;
          r0 = tile_below; r1 = tile_above; r2 = tile_left; r3 = tile_right;
          og = on_ground; hz = hazard_hit;
        end
      end
      if (c == mc) begin map_changed = 1'b1; map_sel = ~map_sel; end
    end
    check({nm, "_done_width"}, done_cnt, 1);
    check({nm, "_done_cycle"}, done_c, exp_done);
    check({nm, "_below"}, r0, e0);
    check({nm, "_above"}, r1, e1);
    check({nm, "_left"},  r2, e2);
    check({nm, "_right"}, r3, e3);
    check({nm, "_on_ground"}, og, int'(e0 == 1));
    check({nm, "_hazard_hit"}, hz, int'(e0 == 2 || e1 == 2 || e2 == 2 || e3 == 2));
    cur = prev_addr;
    for (int c = 1; c < exp_done; c++) begin
      p = issue_probe(c, mc);
      if (p >= 0 && in_map(nb_col(x, p), nb_row(y, p))) cur = nb_row(y, p) * MW + nb_col(x, p);
      check($sformatf("%s_addr_c%0d", nm, c), addr_seen[c], cur);
    end
    prev_addr = cur;
  endtask

  typedef struct {
    int x, y, mc;
    int e_below, e_above, e_left, e_right;
    int e_done;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, y, mc, r, dn, e[4], e2[4];
    int b2b_done [$];
    int b2b_res  [$];
    bit s_used;

    reset = 1'b1; req_valid = 1'b0; map_changed = 1'b0;
    tile_x = '0; tile_y = '0; map_sel = 1'b0;
    for (int a = 0; a < NCELL; a++) begin map_a[a] = 2'd0; map_b[a] = 2'd0; end
    map_a[6*MW + 10] = 2'd1;            // SOLID under (10,5)
    map_a[1*MW + 0]  = 2'd3;            // GOAL below (0,0)
    map_a[0*MW + 1]  = 2'd2;            // HAZARD right of (0,0)
    map_b[6*MW + 10] = 2'd2;            // second map around (10,5)
    map_b[4*MW + 10] = 2'd3;
    map_b[5*MW + 9]  = 2'd1;
    map_b[5*MW + 11] = 2'd0;

    vecs[0] = '{x: 10,  y: 5,   mc: -1, e_below: 1, e_above: 0, e_left: 0, e_right: 0, e_done: 7};
    vecs[1] = '{x: 0,   y: 0,   mc: -1, e_below: 3, e_above: 1, e_left: 1, e_right: 2, e_done: 7};
    vecs[2] = '{x: 127, y: 127, mc: -1, e_below: 2, e_above: 0, e_left: 0, e_right: 1, e_done: 7};
    vecs[3] = '{x: 10,  y: 5,   mc: 3,  e_below: 2, e_above: 3, e_left: 1, e_right: 0, e_done: 10};

    repeat (3) @(negedge clk_75);
    check("rst_ready", int'(req_ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(worldmap_addr), 0);
    check("rst_tiles", int'({tile_below, tile_above, tile_left, tile_right}), 0);
    check("rst_flags", int'({on_ground, hazard_hit}), 0);
    reset = 1'b0;
    prev_addr = 0;

    for (int i = 0; i < 4; i++)
      do_request($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].mc,
                 vecs[i].e_below, vecs[i].e_above, vecs[i].e_left, vecs[i].e_right,
                 vecs[i].e_done);

    // Reset in cycle 4 of a request: nothing is reported, everything clears.
    dn = 0;
    @(negedge clk_75);
    req_valid = 1'b1; tile_x = 7'd10; tile_y = 7'd5;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk_75);
      req_valid = 1'b0;
      if (done) dn++;
      if (c == 5) begin
        check("rstmid_ready", int'(req_ready), 1);
        check("rstmid_addr", int'(worldmap_addr), 0);
        check("rstmid_tiles", int'({tile_below, tile_above, tile_left, tile_right}), 0);
        check("rstmid_flags", int'({on_ground, hazard_hit}), 0);
      end
      reset = (c == 4);
    end
    check("rstmid_no_done", dn, 0);
    prev_addr = 0;
    for (int p = 0; p < 4; p++) e[p] = ref_tile(64, 64, p, map_sel);
    do_request("post_rst", 64, 64, -1, e[0], e[1], e[2], e[3], 5 + RD_LAT);

    // Back-to-back with req_valid held: accepts at cycles 0 and 8 only.
    for (int p = 0; p < 4; p++) begin
      e[p]  = ref_tile(3, 4, p, map_sel);
      e2[p] = ref_tile(20, 30, p, map_sel);
    end
    @(negedge clk_75);
    req_valid = 1'b1; tile_x = 7'd3; tile_y = 7'd4;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk_75);
      if (done) begin
        b2b_done.push_back(c);
        b2b_res.push_back({tile_below, tile_above, tile_left, tile_right});
      end
      if (c <= 16) check($sformatf("b2b_ready_c%0d", c), int'(req_ready), int'(c == 8 || c == 16));
      req_valid = (c < 16);
      if (c == 8) begin tile_x = 7'd20; tile_y = 7'd30; end
      else begin tile_x = 7'($urandom_range(0, 127)); tile_y = 7'($urandom_range(0, 127)); end
    end
    check("b2b_done_count", b2b_done.size(), 2);
    if (b2b_done.size() == 2) begin
      check("b2b_done0_cycle", b2b_done[0], 5 + RD_LAT);
      check("b2b_done1_cycle", b2b_done[1], 2 * (5 + RD_LAT) + 1);
      check("b2b_res0", b2b_res[0], (e[0] << 6) | (e[1] << 4) | (e[2] << 2) | e[3]);
      check("b2b_res1", b2b_res[1], (e2[0] << 6) | (e2[1] << 4) | (e2[2] << 2) | e2[3]);
    end
    prev_addr = final_addr(20, 30, final_addr(3, 4, prev_addr));

    // Randomized maps and requests, edges and map switches favoured.
    for (int a = 0; a < NCELL; a++) begin
      map_a[a] = 2'($urandom_range(0, 3));
      map_b[a] = 2'($urandom_range(0, 3));
    end
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 3);
      x = (r == 0) ? 0 : (r == 1) ? 127 : $urandom_range(0, 127);
      r = $urandom_range(0, 3);
      y = (r == 0) ? 0 : (r == 1) ? 127 : $urandom_range(0, 127);
      mc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8)) : -1;
      s_used = (mc >= 0 && mc <= 6) ? ~map_sel : map_sel;
      for (int p = 0; p < 4; p++) e[p] = ref_tile(x, y, p, s_used);
      do_request($sformatf("rnd%0d", n), x, y, mc, e[0], e[1], e[2], e[3],
                 (mc >= 1 && mc <= 6) ? mc + 5 + RD_LAT : 5 + RD_LAT);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
